// File: rtl/calc_key_pkg.sv
// rtl/calc_key_pkg.sv - key codes, scan FSM states and [col][row] keymap lookup
package calc_key_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_STAR = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = KEY_1;
      4'h1:    code = KEY_2;
      4'h2:    code = KEY_3;
      4'h3:    code = KEY_A;
      4'h4:    code = KEY_4;
      4'h5:    code = KEY_5;
      4'h6:    code = KEY_6;
      4'h7:    code = KEY_B;
      4'h8:    code = KEY_7;
      4'h9:    code = KEY_8;
      4'hA:    code = KEY_9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = KEY_0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // True when exactly one of the four active-low lines is asserted.
  function automatic logic one_cold(input logic [3:0] v);
    return (v == 4'hE) || (v == 4'hD) || (v == 4'hB) || (v == 4'h7);
  endfunction

  function automatic logic [1:0] cold_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'hD:    idx = 2'd1;
      4'hB:    idx = 2'd2;
      4'h7:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and encoded key outputs
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input row_in, output col_out, key_code, key_valid, key_held);
  modport slave  (output row_in, input col_out, key_code, key_valid, key_held);
endinterface

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler, one-clk tick every DIV clks
module scan_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan/debounce/encode; KEY_REPEAT_EN adds auto-repeat
module keypad_scanner
  import calc_key_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_TICKS = 250
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scanner_if.master   kif
);
  localparam int            CW      = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  logic          tick;
  logic [3:0]    rs_meta, rs, latched;
  logic [CW-1:0] cnt;
  scan_state_t   state;
  logic [3:0]    col_out_r, key_code_r;
  logic          key_valid_r, key_held_r;

`ifdef KEY_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt;
`endif

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rs_meta <= kif.row_in;
      rs      <= rs_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      cnt         <= '0;
      latched     <= 4'hF;
      col_out_r   <= 4'b1110;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      key_valid_r <= 1'b0;
`ifdef KEY_REPEAT_EN
      // Counter only runs in PRESSED, so every entry into PRESSED restarts it.
      if (state != PRESSED) rep_cnt <= '0;
`endif
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (one_cold(rs)) begin
              latched <= rs;
              if (DEBOUNCE_CNT == 1) begin
                state       <= PRESSED;
                key_code_r  <= key_lookup(cold_index(col_out_r), cold_index(rs));
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
              end else begin
                cnt   <= CW'(1);
                state <= DEBOUNCE;
              end
            end else begin
              col_out_r <= {col_out_r[2:0], col_out_r[3]};
            end
          end
          DEBOUNCE: begin
            if (rs == latched) begin
              if (cnt == DB_LAST) begin
                state       <= PRESSED;
                cnt         <= '0;
                key_code_r  <= key_lookup(cold_index(col_out_r), cold_index(latched));
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state     <= SCAN;
              cnt       <= '0;
              col_out_r <= {col_out_r[2:0], col_out_r[3]};
            end
          end
          PRESSED: begin
            if (rs == 4'hF) begin
              if (DEBOUNCE_CNT == 1) begin
                state      <= SCAN;
                key_held_r <= 1'b0;
                col_out_r  <= {col_out_r[2:0], col_out_r[3]};
              end else begin
                state <= RELEASE;
                cnt   <= CW'(1);
              end
            end
`ifdef KEY_REPEAT_EN
            else if (rep_cnt == REP_LAST) begin
              key_valid_r <= 1'b1;
              rep_cnt     <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
          RELEASE: begin
            if (rs == 4'hF) begin
              if (cnt == DB_LAST) begin
                state      <= SCAN;
                cnt        <= '0;
                key_held_r <= 1'b0;
                col_out_r  <= {col_out_r[2:0], col_out_r[3]};
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (rs == latched) begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign kif.col_out   = col_out_r;
  assign kif.key_code  = key_code_r;
  assign kif.key_valid = key_valid_r;
  assign kif.key_held  = key_held_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5)
module tb_keypad_scanner;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_TICKS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row_drive;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic prev_valid = 1'b0;

  logic [3:0] exp_q[$];
  int         strobe_t[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_drive = 4'hF;
    for (int c = 0; c < 4; c++)
      if (kif.col_out[c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row_drive[r] = 1'b0;
  end
  assign kif.row_in = row_drive;

  function automatic int kidx(input int c, input int r);
    return c * 4 + r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && kif.key_valid) begin
      check("valid_width", {31'h0, prev_valid}, 32'h0);
      strobe_t.push_back(cyc);
      check("strobe_pending", {31'h0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) check("key_code", {28'h0, kif.key_code}, {28'h0, exp_q.pop_front()});
    end
    prev_valid <= rst ? 1'b0 : kif.key_valid;
  end

  task automatic wait_strobes(input string tag, input int max_clk);
    int n = 0;
    while (exp_q.size() != 0 && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_held_low(input string tag, input int max_clk);
    int n = 0;
    while (kif.key_held && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, kif.key_held}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    int         last;
    int         changes;
    int         n;

    // Reset state and free-running column rotation
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    check("rst_col_out",   {28'h0, kif.col_out},  32'he);
    check("rst_key_valid", {31'h0, kif.key_valid}, 32'h0);
    check("rst_key_held",  {31'h0, kif.key_held},  32'h0);
    check("rst_key_code",  {28'h0, kif.key_code},  32'h0);
    rst = 1'b0;
    prev = kif.col_out; last = -1; changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kif.col_out != prev) begin
        check("col_rotate", {28'h0, kif.col_out}, {28'h0, prev[2:0], prev[3]});
        if (last >= 0) check("col_period", i - last, SCAN_DIV);
        last = i; prev = kif.col_out; changes++;
      end
    end
    check("col_changes", {31'h0, changes >= 4}, 32'h1);

    // Clean press of 5, then release latency of DEBOUNCE_CNT ticks
    exp_q.push_back(4'h5);
    keys[kidx(1, 1)] = 1'b1;
    wait_strobes("press5_strobe", 200);
    check("press5_held", {31'h0, kif.key_held}, 32'h1);
    check("press5_code", {28'h0, kif.key_code}, 32'h5);
    repeat (2 * SCAN_DIV) @(negedge clk);
    keys = '0;
    n = 0;
    while (kif.key_held && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("press5_release_lat", {31'h0, n >= 11 && n <= 14}, 32'h1);
    check("press5_code_kept", {28'h0, kif.key_code}, 32'h5);
    repeat (2 * SCAN_DIV) @(negedge clk);

    // Bouncing * must not strobe until it settles
    for (int i = 0; i < 8; i++) begin
      keys[kidx(0, 3)] = 1'b1;
      repeat (SCAN_DIV) @(negedge clk);
      keys = '0;
      repeat (SCAN_DIV) @(negedge clk);
    end
    exp_q.push_back(4'hF);
    keys[kidx(0, 3)] = 1'b1;
    wait_strobes("bounce_strobe", 200);
    check("bounce_code", {28'h0, kif.key_code}, 32'hf);
    check("bounce_held", {31'h0, kif.key_held}, 32'h1);
    keys = '0;
    wait_held_low("bounce_release", 100);
    repeat (2 * SCAN_DIV) @(negedge clk);

    // Ghost: two rows in column 2, scanning keeps going and nothing is accepted
    keys[kidx(2, 0)] = 1'b1;
    keys[kidx(2, 1)] = 1'b1;
    prev = kif.col_out; changes = 0;
    for (int i = 0; i < 12 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (kif.col_out != prev) begin
        changes++;
        prev = kif.col_out;
      end
    end
    check("ghost_scan", {31'h0, changes >= 8}, 32'h1);
    check("ghost_held", {31'h0, kif.key_held}, 32'h0);
    keys = '0;
    repeat (2 * SCAN_DIV) @(negedge clk);

    // Reset while # is held, then fresh detection after reset
    exp_q.push_back(4'hE);
    keys[kidx(2, 3)] = 1'b1;
    wait_strobes("hash_strobe", 200);
    check("hash_held", {31'h0, kif.key_held}, 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_col_out",  {28'h0, kif.col_out},  32'he);
    check("midrst_held",     {31'h0, kif.key_held},  32'h0);
    check("midrst_code",     {28'h0, kif.key_code},  32'h0);
    check("midrst_valid",    {31'h0, kif.key_valid}, 32'h0);
    rst = 1'b0;
    exp_q.push_back(4'hE);
    wait_strobes("hash_restrobe", 200);
    check("hash_recode", {28'h0, kif.key_code}, 32'he);
    keys = '0;
    wait_held_low("hash_release", 100);
    repeat (2 * SCAN_DIV) @(negedge clk);

    // Hold D for 16 ticks past accept
    strobe_t.delete();
    exp_q.push_back(4'hD);
    keys[kidx(3, 3)] = 1'b1;
    wait_strobes("d_strobe", 200);
`ifdef KEY_REPEAT_EN
    repeat (3) exp_q.push_back(4'hD);
`endif
    repeat (16 * SCAN_DIV) @(negedge clk);
    keys = '0;
    wait_held_low("d_release", 100);
    wait_strobes("d_drain", 10);
`ifdef KEY_REPEAT_EN
    check("d_strobe_count", strobe_t.size(), 4);
    for (int i = 1; i < strobe_t.size(); i++)
      check("d_repeat_gap", strobe_t[i] - strobe_t[i-1], REPEAT_TICKS * SCAN_DIV);
`else
    check("d_strobe_count", strobe_t.size(), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives and scans the calculator's 4x4 matrix keypad, debounces presses, and encodes each accepted press into a 4-bit key code plus a one-cycle valid strobe.
- Feeds the control-output decoder, which consumes {valid, state[1:0], key[3:0]}.
- key_valid supplies the valid bit. key_code supplies the key field.

Parameters:
- SCAN_DIV, 1000: clk cycles per scan tick. Minimum 2.
- DEBOUNCE_CNT, 8: consecutive stable ticks required to accept a press or a release. Minimum 1.
- REPEAT_TICKS, 250: ticks between auto-repeat strobes. Used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- row_in  input  4  keypad rows, active-low (pulled up), asynchronous to clk
- col_out  output  4  column drive, active-low, exactly one bit low
- key_code  output  4  encoded key; 0-9 digits, A=0xA, B=0xB, C=0xC, D=0xD, #=0xE, *=0xF
- key_valid  output  1  one-clk pulse per accepted press
- key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, tick/debounce/column counters=0.
- Row synchronisation: row_in passes through a 2-flop synchroniser. All decisions use the synchronised rows (rs).
- Tick: a one-clk pulse every SCAN_DIV clks from a free-running prescaler. All state decisions occur only on tick.
- Key map, [col][row], col 0..3 by row 0..3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- SCAN:
  - On tick, if rs has exactly one bit low: latch rs, hold the column, cnt=1, go to DEBOUNCE.
  - Otherwise (rs=4'hF, or two or more bits low, i.e. ghost/multi-key): advance the column 0->1->2->3->0.
- DEBOUNCE:
  - On tick, if rs equals the latched value: cnt++.
  - When cnt reaches DEBOUNCE_CNT: go to PRESSED, register key_code, assert key_valid for exactly 1 clk.
  - On any mismatch: return to SCAN and advance the column; no strobe.
- PRESSED:
  - key_held=1; key_code stays stable.
  - On tick with rs=4'hF: go to RELEASE, cnt=1.
  - A second key pressed in the same column is ignored.
- RELEASE:
  - On tick with rs=4'hF: cnt++. When cnt reaches DEBOUNCE_CNT: key_held=0, go to SCAN, advance the column.
  - On tick with the original row low again: return to PRESSED with no new strobe.
- Latency: key_valid rises 1 clk after the tick that completes debounce.
- key_code: holds its last value after release until the next accept.
- DEBOUNCE_CNT=1: accept occurs on the tick of first detection. SCAN goes straight to PRESSED; DEBOUNCE is skipped.
- Reset mid-press: all state clears. A key still held after reset is detected and debounced afresh and yields one new key_valid.
- Column drive changes only on tick. Rows are sampled at the next tick, which allows SCAN_DIV clks of settling.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts ticks.
  - After REPEAT_TICKS ticks it emits another 1-clk key_valid with the same key_code, then reloads.
  - Entering RELEASE resets the counter; returning from RELEASE to PRESSED restarts the count.
- Undefined: exactly one key_valid per press. REPEAT_TICKS is unused and no repeat logic is synthesised.

Decomposition:
- Package calc_key_pkg:
  - key code localparams: KEY_0..KEY_9, KEY_A, KEY_B, KEY_C, KEY_D, KEY_HASH=4'hE, KEY_STAR=4'hF
  - FSM state encoding: SCAN, DEBOUNCE, PRESSED, RELEASE
  - [col][row]-to-code lookup function
- Sub-module scan_tick_gen: prescaler producing the tick pulse. Parameter DIV; ports clk, rst, tick.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5):
- Reset: assert rst for 2 clks. Expect col_out=4'b1110, key_valid=0, key_held=0, key_code=0. Column rotates 1110->1101->1011->0111 every 4 clks.
- Clean press of key 5 (col1/row1): drive row_in=4'b1101 whenever col_out=4'b1101, held for 20 ticks. Expect exactly one key_valid pulse with key_code=4'h5, then key_held=1. On release, key_held drops 3 ticks after rows read all-high.
- Bounce: press * (col0/row3), toggle it off after 1 tick, then hold stably. Expect no strobe during the bounce, then a single key_valid with key_code=4'hF.
- Ghost: two rows low in column 2 (3 and 6... i.e. row0 and row1). Expect no key_valid; scanning continues.
- Reset mid-press: hold # (col2/row3), assert rst while in PRESSED, hold the key after reset. Expect a second key_valid with key_code=4'hE after debounce.
- KEY_REPEAT_EN defined: hold D for 16 ticks after accept. Expect key_valid pulses at accept, +5, +10, and +15 ticks, all with key_code=4'hD. With the macro undefined, expect a single pulse.
